// File: rtl/core_cmt_trap_if.sv
// Commit-stage <-> trap sequencer bundle: retiring instruction, CSR read values,
// CSR update strobes and the fetch flush/redirect handshake.
interface core_cmt_trap_if #(parameter int XLEN = 32);
  logic            cmt_valid;
  logic            cmt_ready;
  logic [XLEN-1:0] cmt_pc;
  logic            cmt_ecall;
  logic            cmt_ebreak;
  logic            cmt_illegal;
  logic            cmt_misalign;
  logic            cmt_mret;
  logic [XLEN-1:0] csr_mstatus_r;
  logic [XLEN-1:0] csr_mtvec_r;
  logic [XLEN-1:0] csr_mepc_r;
  logic            cmt_mstatus_en;
  logic            cmt_mcause_en;
  logic            cmt_mepc_en;
  logic [XLEN-1:0] cmt_mstatus;
  logic [XLEN-1:0] cmt_mcause;
  logic [XLEN-1:0] cmt_mepc;
  logic            cmt_busy;
  logic            flush_req;
  logic [XLEN-1:0] flush_pc;
  logic            flush_ack;

  modport master (
    output cmt_valid, cmt_pc, cmt_ecall, cmt_ebreak, cmt_illegal, cmt_misalign, cmt_mret,
           csr_mstatus_r, csr_mtvec_r, csr_mepc_r, flush_ack,
    input  cmt_ready, cmt_mstatus_en, cmt_mcause_en, cmt_mepc_en,
           cmt_mstatus, cmt_mcause, cmt_mepc, cmt_busy, flush_req, flush_pc
  );

  modport slave (
    input  cmt_valid, cmt_pc, cmt_ecall, cmt_ebreak, cmt_illegal, cmt_misalign, cmt_mret,
           csr_mstatus_r, csr_mtvec_r, csr_mepc_r, flush_ack,
    output cmt_ready, cmt_mstatus_en, cmt_mcause_en, cmt_mepc_en,
           cmt_mstatus, cmt_mcause, cmt_mepc, cmt_busy, flush_req, flush_pc
  );
endinterface

// File: rtl/core_cmt_trap.sv
// Commit-stage trap/mret sequencer: IDLE -> UPD (one-cycle CSR update) -> FLUSH (until ack).
// Optional trap counter enabled by defining CORE_CMT_TRAP_CNT_EN.
module core_cmt_trap #(
  parameter int XLEN     = 32,
  parameter int MCAUSE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  core_cmt_trap_if.slave    bus,
  output logic [31:0]       cmt_trap_cnt
);
  typedef enum logic [1:0] {IDLE, UPD, FLUSH} state_t;

  localparam logic [XLEN-1:0]     ALIGN_MASK   = ~XLEN'(3);
  localparam logic [MCAUSE_W-1:0] CAUSE_MISAL  = MCAUSE_W'(0);
  localparam logic [MCAUSE_W-1:0] CAUSE_ILLEG  = MCAUSE_W'(2);
  localparam logic [MCAUSE_W-1:0] CAUSE_EBREAK = MCAUSE_W'(3);
  localparam logic [MCAUSE_W-1:0] CAUSE_ECALL  = MCAUSE_W'(11);

  state_t              state;
  logic                ready_q, busy_q, flush_q, is_trap_q;
  logic [XLEN-1:0]     pc_q, flush_pc_q;
  logic [MCAUSE_W-1:0] cause_q, cause_d;
  logic                any_exc, accept, in_upd;

  assign any_exc = bus.cmt_misalign | bus.cmt_illegal | bus.cmt_ebreak | bus.cmt_ecall;
  assign accept  = bus.cmt_valid & ready_q;

  always_comb begin
    cause_d = CAUSE_ECALL;
    if (bus.cmt_misalign)     cause_d = CAUSE_MISAL;
    else if (bus.cmt_illegal) cause_d = CAUSE_ILLEG;
    else if (bus.cmt_ebreak)  cause_d = CAUSE_EBREAK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
      is_trap_q  <= 1'b0;
      pc_q       <= '0;
      cause_q    <= '0;
    end else begin
      case (state)
        IDLE: if (accept && (any_exc || bus.cmt_mret)) begin
          pc_q      <= bus.cmt_pc & ALIGN_MASK;
          cause_q   <= cause_d;
          is_trap_q <= any_exc;
          ready_q   <= 1'b0;
          busy_q    <= 1'b1;
          state     <= UPD;
        end
        UPD: begin
          // Redirect target is taken from the CSRs as they stand in the update cycle.
          flush_pc_q <= is_trap_q ? (bus.csr_mtvec_r & ALIGN_MASK) : bus.csr_mepc_r;
          flush_q    <= 1'b1;
          state      <= FLUSH;
        end
        FLUSH: if (bus.flush_ack) begin
          flush_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode the state register; gating with rst drops an update caught by reset.
  assign in_upd = (state == UPD) && !rst;

  always_comb begin
    bus.cmt_mstatus_en = 1'b0;
    bus.cmt_mcause_en  = 1'b0;
    bus.cmt_mepc_en    = 1'b0;
    bus.cmt_mstatus    = '0;
    bus.cmt_mcause     = '0;
    bus.cmt_mepc       = '0;
    if (in_upd) begin
      bus.cmt_mstatus_en     = 1'b1;
      bus.cmt_mstatus        = bus.csr_mstatus_r;
      bus.cmt_mstatus[12:11] = 2'b11;
      if (is_trap_q) begin
        bus.cmt_mstatus[7] = bus.csr_mstatus_r[3];
        bus.cmt_mstatus[3] = 1'b0;
        bus.cmt_mcause_en  = 1'b1;
        bus.cmt_mcause     = {{(XLEN-MCAUSE_W){1'b0}}, cause_q};
        bus.cmt_mepc_en    = 1'b1;
        bus.cmt_mepc       = pc_q;
      end else begin
        bus.cmt_mstatus[3] = bus.csr_mstatus_r[7];
        bus.cmt_mstatus[7] = 1'b1;
      end
    end
  end

  assign bus.cmt_ready = ready_q;
  assign bus.cmt_busy  = busy_q;
  assign bus.flush_req = flush_q;
  assign bus.flush_pc  = flush_pc_q;

`ifdef CORE_CMT_TRAP_CNT_EN
  logic [31:0] trap_cnt_q;
  always_ff @(posedge clk) begin
    if (rst)                 trap_cnt_q <= '0;
    else if (in_upd && is_trap_q) trap_cnt_q <= trap_cnt_q + 32'd1;
  end
  assign cmt_trap_cnt = trap_cnt_q;
`else
  assign cmt_trap_cnt = '0;
`endif
endmodule
